// File: rtl/rev_pe_pkg.sv
// ============================================================================
//  Module      : rev_pe_pkg
//  Description : Shared types and reset constants for the reversible
//                add/subtract pipeline (direction encoding, dual-rail
//                output reset levels).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package rev_pe_pkg;

    // Direction of a beat: forward computes a sum, backward undoes it.
    typedef enum logic {
        DIR_FWD = 1'b0,
        DIR_BWD = 1'b1
    } dir_e;

    // Reset levels for the true and complement rails of every output pair.
    localparam logic c_rail_rst     = 1'b0;
    localparam logic c_rail_not_rst = 1'b1;
    localparam dir_e c_dir_rst      = DIR_FWD;

endpackage : rev_pe_pkg

`default_nettype wire

// File: rtl/rev_add_slice.sv
// ============================================================================
//  Module      : rev_add_slice
//  Description : Combinational SW-bit add (forward) / subtract (backward)
//                segment with carry/borrow in and out.
//  Ports       : dir  - 0 add, 1 subtract
//                a, b - operand slices
//                cin  - carry (fwd) or borrow (bwd) in
//                y    - result slice
//                cout - carry (fwd) or borrow (bwd) out
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rev_add_slice
    import rev_pe_pkg::*;
#(
    parameter int SW = 8
) (
    input  logic          dir,
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] y,
    output logic          cout
);

    logic [SW:0] w_sum;
    logic [SW:0] w_diff;

    assign w_sum  = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};
    // a - b - cin lies in [-2^SW, 2^SW-1]; the extra top bit is set exactly
    // when the result went negative, i.e. it is the borrow out.
    assign w_diff = {1'b0, a} - {1'b0, b} - {{SW{1'b0}}, cin};

    assign y    = (dir == DIR_BWD) ? w_diff[SW-1:0] : w_sum[SW-1:0];
    assign cout = (dir == DIR_BWD) ? w_diff[SW]     : w_sum[SW];

endmodule : rev_add_slice

`default_nettype wire

// File: rtl/rev_add_pipe.sv
// ============================================================================
//  Module      : rev_add_pipe
//  Description : Reversible WIDTH-bit adder/subtractor pipelined along the
//                carry chain in STAGES segments. Forward beats compute
//                a + b + c; backward beats compute a - b - c with borrow.
//                Valid/ready handshake; the whole pipe stalls together.
//  Parameters  : WIDTH  - operand width (multiple of STAGES, >= 2)
//                STAGES - number of pipeline segments (1..WIDTH)
//  Macro       : REV_PE_DUALRAIL_CHECK_EN - when defined, a beat with any
//                non-complementary input rail pair emerges with out_err=1
//                and a zeroed result.
//  Ports       : clk, rst                 - clock, sync active-high reset
//                in_valid/in_ready        - input handshake
//                in_dir                   - 0 add, 1 subtract
//                in_a/_not, in_b/_not     - dual-rail operands
//                in_c/_not                - dual-rail carry/borrow in
//                out_valid/out_ready      - output handshake
//                out_dir                  - direction of result beat
//                out_y/_not, out_c/_not   - dual-rail result and carry out
//                out_z                    - result is zero
//                out_err                  - dual-rail violation on beat
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rev_add_pipe
    import rev_pe_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_dir,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_a_not,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_b_not,
    input  logic             in_c,
    input  logic             in_c_not,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_dir,
    output logic [WIDTH-1:0] out_y,
    output logic [WIDTH-1:0] out_y_not,
    output logic             out_c,
    output logic             out_c_not,
    output logic             out_z,
    output logic             out_err
);

    localparam int c_seg_w = WIDTH / STAGES;

    // Stage registers: stage k holds a beat whose slices 0..k are resolved.
    logic [STAGES-1:0]            r_vld;
    logic [STAGES-1:0]            r_dir;
    logic [STAGES-1:0]            r_cy;
    logic [STAGES-1:0][WIDTH-1:0] r_a;
    logic [STAGES-1:0][WIDTH-1:0] r_b;
    logic [STAGES-1:0][WIDTH-1:0] r_y;

    // What each stage register loads from when the pipe advances.
    logic [STAGES-1:0]              w_src_vld;
    logic [STAGES-1:0]              w_src_dir;
    logic [STAGES-1:0]              w_src_cy;
    logic [STAGES-1:0][WIDTH-1:0]   w_src_a;
    logic [STAGES-1:0][WIDTH-1:0]   w_src_b;
    logic [STAGES-1:0][WIDTH-1:0]   w_src_y;
    logic [STAGES-1:0][WIDTH-1:0]   w_nxt_y;
    logic [STAGES-1:0][c_seg_w-1:0] w_seg_y;
    logic [STAGES-1:0]              w_seg_cy;

    logic             w_adv;
    logic             w_kill;
    logic [WIDTH-1:0] w_y;
    logic             w_c;

    // The pipe moves as one unit: it only freezes when the last stage holds
    // a result nobody is taking.
    assign w_adv    = !r_vld[STAGES-1] || out_ready;
    assign in_ready = w_adv;

    always_comb begin
        w_src_vld[0] = in_valid;
        w_src_dir[0] = in_dir;
        w_src_cy[0]  = in_c;
        w_src_a[0]   = in_a;
        w_src_b[0]   = in_b;
        w_src_y[0]   = '0;
        for (int k = 1; k < STAGES; k++) begin
            w_src_vld[k] = r_vld[k-1];
            w_src_dir[k] = r_dir[k-1];
            w_src_cy[k]  = r_cy[k-1];
            w_src_a[k]   = r_a[k-1];
            w_src_b[k]   = r_b[k-1];
            w_src_y[k]   = r_y[k-1];
        end
    end

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_seg
            rev_add_slice #(
                .SW (c_seg_w)
            ) u_slice (
                .dir  (w_src_dir[k]),
                .a    (w_src_a[k][k*c_seg_w +: c_seg_w]),
                .b    (w_src_b[k][k*c_seg_w +: c_seg_w]),
                .cin  (w_src_cy[k]),
                .y    (w_seg_y[k]),
                .cout (w_seg_cy[k])
            );
        end
    endgenerate

    // Merge each segment's freshly resolved slice into the travelling result.
    always_comb begin
        w_nxt_y = w_src_y;
        for (int k = 0; k < STAGES; k++) begin
            w_nxt_y[k][k*c_seg_w +: c_seg_w] = w_seg_y[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            r_dir <= {STAGES{c_dir_rst}};
            r_cy  <= {STAGES{c_rail_rst}};
            r_a   <= '0;
            r_b   <= '0;
            r_y   <= {(STAGES*WIDTH){c_rail_rst}};
        end else if (w_adv) begin
            r_vld <= w_src_vld;
            r_dir <= w_src_dir;
            r_cy  <= w_seg_cy;
            r_a   <= w_src_a;
            r_b   <= w_src_b;
            r_y   <= w_nxt_y;
        end
    end

    // Operand slices already consumed (and the whole last-stage copy) are
    // carried only to keep the stage structure uniform.
    logic w_unused_ops;
    assign w_unused_ops = ^{r_a, r_b};

`ifdef REV_PE_DUALRAIL_CHECK_EN
    logic [STAGES-1:0] r_err;
    logic              w_in_err;

    // Any bit where a rail equals its complement marks the beat as corrupt.
    assign w_in_err = (|(in_a ~^ in_a_not)) | (|(in_b ~^ in_b_not))
                    | (in_c ~^ in_c_not);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= '0;
        end else if (w_adv) begin
            r_err[0] <= w_in_err;
            for (int k = 1; k < STAGES; k++) begin
                r_err[k] <= r_err[k-1];
            end
        end
    end

    assign w_kill = r_err[STAGES-1];
`else
    logic w_unused_rails;
    assign w_unused_rails = ^{in_a_not, in_b_not, in_c_not};
    assign w_kill         = 1'b0;
`endif

    assign w_y = w_kill ? '0   : r_y[STAGES-1];
    assign w_c = w_kill ? 1'b0 : r_cy[STAGES-1];

    assign out_valid = r_vld[STAGES-1];
    assign out_dir   = r_dir[STAGES-1];
    assign out_y     = w_y;
    assign out_y_not = ~w_y;
    assign out_c     = w_c;
    assign out_c_not = ~w_c;
    assign out_z     = (w_y == '0);
    assign out_err   = w_kill;

endmodule : rev_add_pipe

`default_nettype wire

// File: tb/tb_rev_add_pipe.sv
// ============================================================================
//  Module      : tb_rev_add_pipe
//  Description : Self-checking bench for rev_add_pipe (WIDTH=16, STAGES=2)
//                with an arithmetic reference model and a scoreboard queue.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rev_add_pipe;

    localparam int WIDTH  = 16;
    localparam int STAGES = 2;

`ifdef REV_PE_DUALRAIL_CHECK_EN
    localparam bit c_chk_en = 1'b1;
`else
    localparam bit c_chk_en = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_dir = 1'b0;
    logic [WIDTH-1:0]  in_a = '0, in_a_not = '1, in_b = '0, in_b_not = '1;
    logic              in_c = 1'b0, in_c_not = 1'b1;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              out_dir;
    logic [WIDTH-1:0]  out_y, out_y_not;
    logic              out_c, out_c_not, out_z, out_err;

    always #5 clk = ~clk;

    rev_add_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_dir(in_dir),
        .in_a(in_a), .in_a_not(in_a_not), .in_b(in_b), .in_b_not(in_b_not),
        .in_c(in_c), .in_c_not(in_c_not),
        .out_valid(out_valid), .out_ready(out_ready), .out_dir(out_dir),
        .out_y(out_y), .out_y_not(out_y_not), .out_c(out_c),
        .out_c_not(out_c_not), .out_z(out_z), .out_err(out_err)
    );

    typedef struct packed {
        logic        dir;
        logic [15:0] y;
        logic        c;
        logic        err;
    } beat_t;

    beat_t       exp_q[$];
    logic [15:0] seen_y[$];
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference: plain integer arithmetic on the whole word.
    function automatic beat_t model(input logic dir, input logic [15:0] a, input logic [15:0] an,
                                    input logic [15:0] b, input logic [15:0] bn,
                                    input logic c, input logic cn);
        beat_t       r;
        int unsigned sa, sb, sc, s;
        bit          bad;
        sa  = a;
        sb  = b;
        sc  = c;
        bad = ((a ^ an) != 16'hFFFF) || ((b ^ bn) != 16'hFFFF) || (c == cn);
        r.dir = dir;
        r.err = c_chk_en && bad;
        if (r.err) begin
            r.y = 16'h0;
            r.c = 1'b0;
        end else if (!dir) begin
            s   = sa + sb + sc;
            r.y = s[15:0];
            r.c = s[16];
        end else begin
            s   = sa - sb - sc;
            r.y = s[15:0];
            r.c = (sa < sb + sc);
        end
        return r;
    endfunction

    // Scoreboard: capture accepted beats, check delivered beats, rails, stalls.
    logic        stall_prev = 1'b0;
    logic [19:0] snap_prev  = '0;

    always @(negedge clk) begin
        beat_t e;
        chk("y_rail", 32'(out_y ^ out_y_not), 32'h0000FFFF);
        chk("c_rail", 32'(out_c ^ out_c_not), 32'h1);
        if (rst) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                chk("stall_hold", 32'({out_valid, out_dir, out_y, out_c, out_err}), 32'(snap_prev));
            if (in_valid && in_ready)
                exp_q.push_back(model(in_dir, in_a, in_a_not, in_b, in_b_not, in_c, in_c_not));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL spurious: got beat y=0x%0h, expected none", out_y);
                end else begin
                    e = exp_q.pop_front();
                    chk("y",   32'(out_y),   32'(e.y));
                    chk("c",   32'(out_c),   32'(e.c));
                    chk("dir", 32'(out_dir), 32'(e.dir));
                    chk("err", 32'(out_err), 32'(e.err));
                    chk("z",   32'(out_z),   32'(e.y == 16'h0));
                end
                seen_y.push_back(out_y);
            end
            stall_prev = out_valid && !out_ready;
            snap_prev  = {out_valid, out_dir, out_y, out_c, out_err};
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat starting now (posedge+1) and hold it until accepted.
    task automatic send(input logic dir, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic [15:0] a_flip);
        bit acc, ok;
        in_valid = 1'b1;
        in_dir   = dir;
        in_a     = a;
        in_a_not = ~a ^ a_flip;
        in_b     = b;
        in_b_not = ~b;
        in_c     = c;
        in_c_not = ~c;
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout: got no acceptance, expected in_ready within 50 cycles");
        end
    endtask

    // Count cycles from acceptance until out_valid is seen.
    task automatic wait_out(output int lat);
        lat = 1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (out_valid) return;
            lat++;
        end
        lat = -1;
    endtask

    task automatic drain();
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) return;
        end
        n_vec++;
        n_bad++;
        $display("FAIL drain_timeout: got %0d beats pending, expected 0", exp_q.size());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int    lat;
        int    base;
        beat_t m;
        bit    done;

        // Offer beats throughout reset; none may be accepted.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a = 16'($urandom);
            in_a_not = ~in_a;
            sync();
        end
        @(negedge clk);
        chk("rst_valid",  32'(out_valid), 32'h0);
        chk("rst_ready",  32'(in_ready),  32'h1);
        chk("rst_y",      32'(out_y),     32'h0);
        chk("rst_y_not",  32'(out_y_not), 32'hFFFF);
        chk("rst_c",      32'(out_c),     32'h0);
        chk("rst_c_not",  32'(out_c_not), 32'h1);
        chk("rst_z",      32'(out_z),     32'h1);
        chk("rst_err",    32'(out_err),   32'h0);
        chk("rst_dir",    32'(out_dir),   32'h0);
        sync();
        rst      = 1'b0;
        in_valid = 1'b0;

        // Pin the reference model with hand-computed values.
        m = model(1'b0, 16'hFFFF, 16'h0000, 16'h0001, 16'hFFFE, 1'b0, 1'b1);
        chk("model_fwd_wrap", 32'({m.c, m.y}), 32'h10000);
        m = model(1'b1, 16'h0000, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b1);
        chk("model_bwd_wrap", 32'({m.c, m.y}), 32'h1FFFF);
        m = model(1'b1, 16'h1235, 16'hEDCA, 16'h0234, 16'hFDCB, 1'b1, 1'b0);
        chk("model_bwd_inv", 32'({m.c, m.y}), 32'h01000);

        // Basic forward sum, latency and complement rail.
        sync();
        send(1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0);
        wait_out(lat);
        chk("lat_fwd",   32'(lat),       32'(STAGES));
        chk("fwd_y",     32'(out_y),     32'h0100);
        chk("fwd_y_not", 32'(out_y_not), 32'hFEFF);
        chk("fwd_c",     32'(out_c),     32'h0);
        chk("fwd_z",     32'(out_z),     32'h0);

        // Wrap-around in both directions.
        sync();
        send(1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0);
        wait_out(lat);
        chk("wrap_fwd_y", 32'(out_y), 32'h0000);
        chk("wrap_fwd_c", 32'(out_c), 32'h1);
        chk("wrap_fwd_z", 32'(out_z), 32'h1);
        sync();
        send(1'b1, 16'h0000, 16'h0001, 1'b0, 16'h0);
        wait_out(lat);
        chk("wrap_bwd_y",   32'(out_y),   32'hFFFF);
        chk("wrap_bwd_c",   32'(out_c),   32'h1);
        chk("wrap_bwd_dir", 32'(out_dir), 32'h1);

        // Three back-to-back mixed beats against a stalled consumer.
        drain();
        base = seen_y.size();
        sync();
        out_ready = 1'b0;
        fork
            begin
                send(1'b0, 16'h1000, 16'h0234, 1'b1, 16'h0);
                send(1'b1, 16'h5000, 16'h0001, 1'b1, 16'h0);
                send(1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0);
            end
            begin
                for (int t = 0; t < 20 && !out_valid; t++) @(negedge clk);
                for (int t = 0; t < 5; t++) begin
                    @(negedge clk);
                    chk("stall_in_ready", 32'(in_ready), 32'h0);
                end
                sync();
                out_ready = 1'b1;
            end
        join
        drain();
        if (seen_y.size() >= base + 3) begin
            chk("order_0", 32'(seen_y[base]),     32'h1235);
            chk("order_1", 32'(seen_y[base + 1]), 32'h4FFE);
            chk("order_2", 32'(seen_y[base + 2]), 32'h0000);
        end else begin
            n_vec++;
            n_bad++;
            $display("FAIL order_count: got %0d beats, expected 3", seen_y.size() - base);
        end

        // Dual-rail violation on a bit 4.
        sync();
        send(1'b0, 16'h0010, 16'h0001, 1'b0, 16'h0010);
        wait_out(lat);
        chk("dr_err", 32'(out_err), 32'(c_chk_en));
        chk("dr_y",   32'(out_y),   c_chk_en ? 32'h0 : 32'h0011);
        chk("dr_z",   32'(out_z),   32'(c_chk_en));

        // Reset one cycle after acceptance discards the beat.
        drain();
        sync();
        send(1'b0, 16'h0F0F, 16'h0101, 1'b0, 16'h0);
        rst = 1'b1;
        sync();
        rst = 1'b0;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            chk("rst_flush_valid", 32'(out_valid), 32'h0);
        end
        sync();
        send(1'b0, 16'h1234, 16'h4321, 1'b1, 16'h0);
        wait_out(lat);
        chk("post_rst_lat", 32'(lat),   32'(STAGES));
        chk("post_rst_y",   32'(out_y), 32'h5556);

        // Randomized traffic with random backpressure.
        drain();
        sync();
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    repeat ($urandom_range(0, 2)) sync();
                    send(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
                         ($urandom_range(0, 9) == 0) ? (16'h1 << $urandom_range(0, 15)) : 16'h0);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    sync();
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_rev_add_pipe

`default_nettype wire

// File: doc/rev_add_pipe.md
REV_ADD_PIPE -- requirements
Module: rev_add_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits (multiple of STAGES, >= 2).
REQ-002 SHALL have parameter STAGES, default 2, number of pipeline segments along the carry chain (1..WIDTH).
REQ-003 SHALL have one clock, clk; reset is synchronous and active-high, rst.
REQ-004 Ports, in order:
  clk  in  1  clock
  rst  in  1  synchronous active-high reset
  in_valid  in  1  operand beat offered
  in_ready  out  1  operand beat accepted when in_valid && in_ready
  in_dir  in  1  0 = forward (add), 1 = backward (uncompute)
  in_a / in_a_not  in  WIDTH  operand A, dual-rail
  in_b / in_b_not  in  WIDTH  operand B, dual-rail
  in_c / in_c_not  in  1  carry/borrow in, dual-rail
  out_valid  out  1  result beat offered
  out_ready  in  1  result beat consumed when out_valid && out_ready
  out_dir  out  1  direction of this result
  out_y / out_y_not  out  WIDTH  result, dual-rail
  out_c / out_c_not  out  1  carry/borrow out, dual-rail
  out_z  out  1  out_y == 0
  out_err  out  1  dual-rail violation on this beat

Function
REQ-005 Forward: {out_c, out_y} = in_a + in_b + in_c, (WIDTH+1)-bit exact.
REQ-006 Backward: out_y = (in_a - in_b - in_c) mod 2^WIDTH; out_c = 1 iff in_a < in_b + in_c (borrow); recovers the forward A from forward Y and B.
REQ-007 Latency exactly STAGES cycles from acceptance to out_valid when out_ready held high; throughput one beat per cycle.
REQ-008 Segment k (0..STAGES-1) resolves bits [k*W/S +: W/S] using the carry registered by segment k-1; unresolved operand slices and direction travel with the beat.
REQ-009 Pipeline stalls as a whole: in_ready = !out_valid || out_ready; no stage advances while out_valid && !out_ready.
REQ-010 While stalled, out_* SHALL hold stable; no beat is dropped, duplicated or reordered.
REQ-011 Bubbles SHALL propagate as invalid stages; valid bits are per stage.
REQ-012 Every output rail pair SHALL be complementary on every cycle: out_y_not = ~out_y, out_c_not = ~out_c.
REQ-013 Mixed forward/backward beats back-to-back SHALL each use their own in_dir.
REQ-014 Wrap-around: forward 0xFFFF+0x0001+0 gives y=0x0000, c=1, z=1; backward 0x0000-0x0001-0 gives y=0xFFFF, c=1.

Reset
REQ-015 On rst all stage valid bits clear; next cycle out_valid=0, in_ready=1, out_y=0, out_y_not=all ones, out_c=0, out_c_not=1, out_z=1, out_err=0, out_dir=0.
REQ-016 Reset mid-operation SHALL discard all in-flight beats; no result for them ever appears.
REQ-017 Inputs presented during rst SHALL NOT be accepted.

Configuration
REQ-018 Macro REV_PE_DUALRAIL_CHECK_EN: when defined, a beat whose any input pair (a/a_not, b/b_not, c/c_not) is non-complementary in any bit SHALL emerge with out_err=1, out_y=0, out_c=0, out_z=1, same latency and order.
REQ-019 Without REV_PE_DUALRAIL_CHECK_EN: *_not inputs ignored, out_err tied 0, no check logic synthesised.

Structure
REQ-020 Shared package rev_pe_pkg SHALL hold dir_e (DIR_FWD=0, DIR_BWD=1) and the reset constants for dual-rail outputs.
REQ-021 One sub-module rev_add_slice SHALL implement a combinational W/S-bit add/subtract segment with carry in/out; rev_add_pipe instantiates STAGES of them plus registers.

Verification (WIDTH=16, STAGES=2)
REQ-022 Fwd a=0x00FF b=0x0001 c=0 -> 2 cycles later y=0x0100, y_not=0xFEFF, c=0, z=0.
REQ-023 Fwd a=0xFFFF b=0x0001 c=0 -> y=0x0000, c=1, z=1; then bwd a=0x0000 b=0x0001 c=0 -> y=0xFFFF, c=1.
REQ-024 Three back-to-back beats, out_ready low 5 cycles -> in_ready low while full, outputs stable, all three delivered in order once out_ready rises.
REQ-025 Macro defined, a=0x0010 with a_not bit4 = 1 -> out_err=1, y=0, z=1; macro undefined, same stimulus -> normal sum, out_err=0.
REQ-026 rst asserted one cycle after accepting a beat -> out_valid stays 0 for that beat; next beat after reset returns correct sum with latency 2.
